// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt controller: FSM encoding, register
// word offsets and the source-count ceiling.
package irq_pkg;

    typedef enum logic [1:0] {
        IRQ_IDLE    = 2'd0,
        IRQ_ASSERT  = 2'd1,
        IRQ_SERVICE = 2'd2
    } irq_state_e;

    // Word indices relative to the block base (byte offset >> 2)
    localparam logic [2:0] OFF_ENABLE  = 3'd0;
    localparam logic [2:0] OFF_PENDING = 3'd1;
    localparam logic [2:0] OFF_CAUSE   = 3'd2;
    localparam logic [2:0] OFF_EOI     = 3'd3;
    localparam logic [2:0] OFF_OVERRUN = 3'd4;

    localparam int MAX_SRC = 8;

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: lowest set request index wins.
module irq_prio_enc #(
    parameter int N = 4
) (
    input  logic [N-1:0] req,
    output logic [2:0]   win_id,
    output logic         any_req
);

    always_comb begin
        win_id = 3'd0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                win_id = 3'(i);
            end
        end
        any_req = |req;
    end

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller for the single-cycle MIPS core: edge-latched pending,
// mask, priority, kernel-entry sequencing. Define IRQ_OVERRUN_EN to add OVERRUN.
module irq_ctrl
    import irq_pkg::*;
#(
    parameter int          NSRC = 4,
    parameter logic [31:0] BASE = 32'h40000030
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NSRC-1:0] src_irq,
    input  logic            ker,
    input  logic            rd,
    input  logic            wr,
    input  logic [31:0]     addr,
    input  logic [31:0]     wdata,
    output logic [31:0]     rdata,
    output logic            irq_out,
    output logic            busy
);

    irq_state_e      state_reg, state_next;
    logic [NSRC-1:0] enable_reg;
    logic [NSRC-1:0] pending_reg, pending_next;
    logic [NSRC-1:0] src_d_reg;
    logic [2:0]      id_reg;
    logic            armed_reg;

    logic [NSRC-1:0] rise, req, clr, sw_clr, svc_clr;
    logic [2:0]      win_id;
    logic            any_req;
    logic            svc_entry;

    logic [31:0] offset;
    logic [2:0]  word;
    logic        hit;
    logic        wr_hit;

    assign offset = addr - BASE;

`ifdef IRQ_OVERRUN_EN
    assign hit  = (offset[31:5] == 27'd0);
    assign word = offset[4:2];
`else
    assign hit  = (offset[31:4] == 28'd0);
    assign word = {1'b0, offset[3:2]};
`endif

    assign wr_hit = wr && hit;

    logic unused_ok;
    assign unused_ok = &{1'b0, offset[4], offset[1:0], wdata};

    // armed_reg masks the first edge after reset so a source already high
    // at release does not register as a new rising edge.
    assign sw_clr  = (wr_hit && word == OFF_PENDING) ? wdata[NSRC-1:0] : '0;
    assign svc_clr = svc_entry ? (NSRC'(1) << win_id) : '0;
    assign clr     = sw_clr | svc_clr;
    assign req     = pending_reg & enable_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NSRC; gi++) begin : g_bit
            assign rise[gi]         = src_irq[gi] & ~src_d_reg[gi] & armed_reg;
            assign pending_next[gi] = (pending_reg[gi] & ~clr[gi]) | rise[gi];
        end
    endgenerate

    irq_prio_enc #(.N(NSRC)) u_prio (
        .req     (req),
        .win_id  (win_id),
        .any_req (any_req)
    );

    always_comb begin
        state_next = state_reg;
        svc_entry  = 1'b0;
        case (state_reg)
            IRQ_IDLE: begin
                if (any_req && !ker) state_next = IRQ_ASSERT;
            end
            IRQ_ASSERT: begin
                if (ker) begin
                    state_next = IRQ_SERVICE;
                    svc_entry  = 1'b1;
                end else if (!any_req) begin
                    state_next = IRQ_IDLE;
                end
            end
            IRQ_SERVICE: begin
                if (wr_hit && word == OFF_EOI) state_next = IRQ_IDLE;
            end
            default: state_next = IRQ_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= IRQ_IDLE;
            enable_reg  <= '0;
            pending_reg <= '0;
            src_d_reg   <= '0;
            id_reg      <= 3'd0;
            armed_reg   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            pending_reg <= pending_next;
            src_d_reg   <= src_irq;
            armed_reg   <= 1'b1;
            if (svc_entry) id_reg <= win_id;
            if (wr_hit && word == OFF_ENABLE) enable_reg <= wdata[NSRC-1:0];
        end
    end

`ifdef IRQ_OVERRUN_EN
    logic [NSRC-1:0] overrun_reg, overrun_next, ovr_clr;

    assign ovr_clr = (wr_hit && word == OFF_OVERRUN) ? wdata[NSRC-1:0] : '0;

    generate
        for (gi = 0; gi < NSRC; gi++) begin : g_ovr
            assign overrun_next[gi] = (overrun_reg[gi] & ~ovr_clr[gi])
                                    | (rise[gi] & pending_reg[gi] & ~clr[gi]);
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overrun_reg <= '0;
        end else begin
            overrun_reg <= overrun_next;
        end
    end
`endif

    assign irq_out = (state_reg == IRQ_ASSERT);
    assign busy    = (state_reg == IRQ_SERVICE);

    always_comb begin
        rdata = 32'h0;
        if (rd && hit) begin
            case (word)
                OFF_ENABLE:  rdata[NSRC-1:0] = enable_reg;
                OFF_PENDING: rdata[NSRC-1:0] = pending_reg;
                OFF_CAUSE:   rdata = {busy, 28'd0, id_reg};
`ifdef IRQ_OVERRUN_EN
                OFF_OVERRUN: rdata[NSRC-1:0] = overrun_reg;
`endif
                default:     rdata = 32'h0;
            endcase
        end
    end

endmodule
